avmm_burst_responder: RTL and testbench



---
 rtl/bpfcap_pkg.sv | 15 +
 rtl/resp_ram.sv | 32 +++
 rtl/avmm_burst_responder.sv | 149 ++++++++++++++
 tb/tb_avmm_burst_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpfcap_pkg.sv
// Shared types and defaults for the Avalon-MM burst responder.
package bpfcap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST
    } resp_state_t;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_BURST_W = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous word RAM with a registered, resettable read port.
// Only the output register is reset; the array keeps its contents.
module resp_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic                     re,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/avmm_burst_responder.sv
// Avalon-MM burst agent backed by resp_ram; one outstanding burst at a time.
// Optional BURST_RESP_STALL_EN inserts LFSR-driven waitrequest stalls in IDLE/WR_BURST.
module avmm_burst_responder
    import bpfcap_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [DATA_W-1:0]  avs_writedata,
    input  logic [BURST_W-1:0] avs_burstcount,
    output logic               avs_waitrequest,
    output logic [DATA_W-1:0]  avs_readdata,
    output logic               avs_readdatavalid,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    resp_state_t        state, state_n;
    logic [IDX_W-1:0]   base, base_n;
    logic [BURST_W-1:0] cnt, cnt_n;
    logic [BURST_W-1:0] beat, beat_n;
    logic               busy_n, wait_n;
    logic               stall_n;
    logic [IDX_W-1:0]   ram_addr;
    logic               ram_we, ram_re;
    logic [IDX_W-1:0]   cmd_idx;
    logic [BURST_W-1:0] cmd_cnt;
    logic               unused_addr;

    assign cmd_idx     = avs_address[IDX_W+1:2];
    assign cmd_cnt     = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
    assign unused_addr = ^{avs_address[ADDR_W-1:IDX_W+2], avs_address[1:0]};

`ifdef BURST_RESP_STALL_EN
    logic [15:0] lfsr, lfsr_n;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepping every cycle
    assign lfsr_n  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall_n = (lfsr_n[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_n;
        end
    end
`else
    assign stall_n = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            base              <= '0;
            cnt               <= '0;
            beat              <= '0;
            avs_waitrequest   <= 1'b0;
            avs_readdatavalid <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= state_n;
            base              <= base_n;
            cnt               <= cnt_n;
            beat              <= beat_n;
            avs_waitrequest   <= wait_n;
            avs_readdatavalid <= ram_re;
            busy              <= busy_n;
        end
    end

    // Next state, beat bookkeeping and RAM control
    always_comb begin
        state_n  = state;
        base_n   = base;
        cnt_n    = cnt;
        beat_n   = beat;
        ram_addr = base + IDX_W'(beat);
        ram_we   = 1'b0;
        ram_re   = 1'b0;

        unique case (state)
            IDLE: begin
                ram_addr = cmd_idx;
                if (!avs_waitrequest && avs_write) begin
                    ram_we = 1'b1;
                    base_n = cmd_idx;
                    cnt_n  = cmd_cnt;
                    if (cmd_cnt != BURST_W'(1)) begin
                        state_n = WR_BURST;
                        beat_n  = BURST_W'(1);
                    end
                end else if (!avs_waitrequest && avs_read) begin
                    base_n  = cmd_idx;
                    cnt_n   = cmd_cnt;
                    beat_n  = '0;
                    state_n = RD_BURST;
                end
            end
            WR_BURST: begin
                if (!avs_waitrequest && avs_write) begin
                    ram_we = 1'b1;
                    if (beat == cnt - BURST_W'(1)) begin
                        state_n = IDLE;
                        beat_n  = '0;
                    end else begin
                        beat_n = beat + BURST_W'(1);
                    end
                end
            end
            RD_BURST: begin
                // Stay one extra cycle so the last registered beat is delivered while busy
                if (beat != cnt) begin
                    ram_re = 1'b1;
                    beat_n = beat + BURST_W'(1);
                end else begin
                    state_n = IDLE;
                    beat_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
        wait_n = (state_n == RD_BURST) || stall_n;
    end

    resp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .addr  (ram_addr),
        .we    (ram_we),
        .re    (ram_re),
        .wdata (avs_writedata),
        .rdata (avs_readdata)
    );

endmodule

// File: tb/tb_avmm_burst_responder.sv
// Scoreboard bench for avmm_burst_responder: word-array reference memory,
// expected read beats (data + arrival cycle) queued at command acceptance.
module tb_avmm_burst_responder;

    localparam int unsigned DEPTH = 1024;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [15:0] avs_burstcount = '0;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    int unsigned stalls = 0;
    logic [31:0] model_mem [DEPTH];
    exp_t        exp_q[$];
    logic [31:0] dq[$];

    avmm_burst_responder dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_burstcount    (avs_burstcount),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .busy              (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every returned beat must match the oldest expected beat and its cycle
    always @(negedge clk) begin
        if (avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdv", 32'(avs_readdatavalid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", avs_readdata, e.data);
                check("rd_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int unsigned k = 0;
        while (avs_waitrequest) begin
            stalls++;
            k++;
            if (k > 1000) begin
                $display("FAIL wait_ready: waitrequest stuck high at cycle %0d", cyc);
                $fatal(1);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int unsigned k = 0;
        while (busy || exp_q.size() != 0) begin
            k++;
            if (k > 1000) begin
                miscompares++;
                $display("FAIL wait_idle: burst never finished, busy=%0d pending=%0d", busy, exp_q.size());
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [15:0] bc, input bit gaps);
        int unsigned n = (bc == 0) ? 1 : int'(bc);
        int unsigned w0 = int'(addr[11:2]);
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk);
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                avs_write = 1'b0;
                @(negedge clk);
            end
            avs_write      = 1'b1;
            avs_address    = (i == 0) ? addr : $urandom;
            avs_burstcount = (i == 0) ? bc : 16'($urandom);
            avs_writedata  = dq[i];
            wait_ready();
            check("wr_busy", 32'(busy), (i > 0) ? 32'd1 : 32'd0);
            model_mem[(w0 + i) % DEPTH] = dq[i];
        end
        @(negedge clk);
        avs_write = 1'b0;
        check("wr_done_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [15:0] bc);
        int unsigned n = (bc == 0) ? 1 : int'(bc);
        int unsigned w0 = int'(addr[11:2]);
        int unsigned acc;
        @(negedge clk);
        avs_read       = 1'b1;
        avs_address    = addr;
        avs_burstcount = bc;
        wait_ready();
        acc = cyc;
        for (int j = 0; j < int'(n); j++) begin
            exp_q.push_back('{model_mem[(w0 + j) % DEPTH], acc + 2 + j});
        end
        @(negedge clk);
        avs_read = 1'b0;
        check("rd_wait_high", 32'(avs_waitrequest), 32'd1);
        check("rd_busy", 32'(busy), 32'd1);
        wait_idle();
    endtask

    task automatic fill_random(input int unsigned n);
        dq.delete();
        for (int i = 0; i < int'(n); i++) dq.push_back($urandom);
    endtask

    initial begin
        int unsigned acc;

        repeat (3) @(negedge clk);
        check("rst_wait", 32'(avs_waitrequest), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Basic 4-beat write then read back
        dq = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_write(32'h40, 16'd4, 1'b0);
        do_read(32'h40, 16'd4);

        // Wrap: last word then word 0
        dq = '{32'hA5A5_0001, 32'hA5A5_0002};
        do_write(32'hFFC, 16'd2, 1'b0);
        do_read(32'h0, 16'd1);
        do_read(32'hFFC, 16'd1);

        // Read and write together: write wins, read dropped
        @(negedge clk);
        avs_read = 1'b1; avs_write = 1'b1;
        avs_address = 32'h80; avs_burstcount = 16'd1; avs_writedata = 32'h5A5A_C3C3;
        wait_ready();
        model_mem[32] = 32'h5A5A_C3C3;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rw_no_rdv", 32'(avs_readdatavalid), 32'd0);
            check("rw_idle", 32'(busy), 32'd0);
            @(negedge clk);
        end
        do_read(32'h80, 16'd1);

        // Reset during the 3rd beat of an 8-beat read
        @(negedge clk);
        avs_read = 1'b1; avs_address = 32'h40; avs_burstcount = 16'd8;
        wait_ready();
        acc = cyc;
        for (int j = 0; j < 8; j++) exp_q.push_back('{model_mem[16 + j], acc + 2 + j});
        @(negedge clk);
        avs_read = 1'b0;
        while (cyc < acc + 4) @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_rdv", 32'(avs_readdatavalid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wait", 32'(avs_waitrequest), 32'd0);
        reset = 1'b0;
        do_read(32'h40, 16'd4);

        // Burstcount 0 behaves as 1
        dq = '{32'h0000_DEAD};
        do_write(32'h10, 16'd0, 1'b0);
        do_read(32'h10, 16'd0);

        // Read-after-write: read accepted right after the final beat
        fill_random(3);
        do_write(32'h200, 16'd3, 1'b0);
        do_read(32'h200, 16'd3);

        // Preload the whole memory in 64-beat bursts with idle gaps and junk upper address bits
        for (int b = 0; b < 16; b++) begin
            fill_random(64);
            do_write({20'($urandom), 12'(b * 256)} | 32'($urandom_range(0, 3)), 16'd64, 1'b1);
        end
        do_read(32'h100, 16'd64);

        // Random mix of bursts anywhere in memory
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [15:0] bc;
            a  = $urandom;
            bc = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 1) == 0) begin
                fill_random((bc == 0) ? 1 : int'(bc));
                do_write(a, bc, 1'b1);
            end else begin
                do_read(a, bc);
            end
        end

`ifdef BURST_RESP_STALL_EN
        check("stall_seen", 32'(stalls > 0), 32'd1);
`else
        check("no_stall", stalls, 32'd0);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
